spi_slave_fifo: RTL and testbench

SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

---
 rtl/spi_slave_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 45 ++++
 rtl/spi_slave_fifo.sv | 166 ++++++++++++++++
 tb/tb_spi_slave_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave with RX/TX FIFOs.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int STAT_RX_OK    = 5;
    localparam int STAT_TX_VALID = 6;

    localparam logic [7:0] INIT_OPCODE = 8'h01;

    function automatic logic [7:0] make_status(input logic rx_ok, input logic tx_present);
        logic [7:0] s;
        s                = '0;
        s[STAT_RX_OK]    = rx_ok;
        s[STAT_TX_VALID] = tx_present;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave, oversampled by clk, with RX/TX FIFOs and an 8-bit status header.
// Optional SPI_SLAVE_INIT_OPCODE_EN: stay locked until a frame with opcode 0x01.
module spi_slave_fifo
    import spi_slave_pkg::*;
#(
    parameter int FRAME_W  = 32,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               SPI_SCK,
    input  logic               SPI_SS,
    input  logic               SPI_MOSI,
    output logic               SPI_MISO,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [FRAME_W-9:0] tx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_overflow
);
    localparam int   PAY_W        = FRAME_W - 8;
    localparam int   CNT_W        = $clog2(FRAME_W) + 1;
    localparam int   IDX_W        = $clog2(FRAME_W);
    localparam logic SCK_IDLE     = (CPOL != 0);
    localparam logic SAMPLE_TRAIL = (CPHA != 0);

    state_t             state, state_next;
    logic [2:0]         sck_q, ss_q;
    logic [1:0]         mosi_q;
    logic               sck_lead, sck_trail, sample_edge, shift_edge;
    logic               ss_fall, ss_rise, last_bit, commit, unlocked;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] rx_shift, tx_shift, next_frame;
    logic               tx_sent, tx_avail;
    logic               rx_full, rx_empty, rx_push, rx_pop;
    logic               tx_full, tx_empty, tx_push, tx_pop;
    logic [PAY_W-1:0]   tx_head;

    // SS resets to "low" so a frame already in progress at reset release never looks like a fresh fall.
    // NOTE: all clocked state uses <= so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q  <= {3{SCK_IDLE}};
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], SPI_SCK};
            ss_q   <= {ss_q[1:0], SPI_SS};
            mosi_q <= {mosi_q[0], SPI_MOSI};
        end
    end

    assign sck_lead    = (sck_q[2] == SCK_IDLE) && (sck_q[1] != SCK_IDLE);
    assign sck_trail   = (sck_q[2] != SCK_IDLE) && (sck_q[1] == SCK_IDLE);
    assign sample_edge = SAMPLE_TRAIL ? sck_trail : sck_lead;
    assign shift_edge  = SAMPLE_TRAIL ? sck_lead : sck_trail;
    assign ss_fall     = ss_q[2] && !ss_q[1];
    assign ss_rise     = !ss_q[2] && ss_q[1];
    assign last_bit    = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign commit      = (state == ST_COMMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: default assigned first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (ss_fall) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (ss_rise)                      state_next = ST_IDLE;
                else if (sample_edge && last_bit) state_next = ST_COMMIT;
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

`ifdef SPI_SLAVE_INIT_OPCODE_EN
    logic locked;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       locked <= 1'b1;
        else if (commit && rx_shift[7:0] == INIT_OPCODE) locked <= 1'b0;
    end
    assign unlocked = !locked;
`else
    assign unlocked = 1'b1;
`endif

    assign tx_avail   = !tx_empty && unlocked;
    assign next_frame = {{PAY_W{tx_avail}} & tx_head, make_status(!rx_full, tx_avail)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_sent     <= 1'b0;
            SPI_MISO    <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_overflow <= 1'b0;
            case (state)
                ST_IDLE: begin
                    SPI_MISO <= 1'b0;
                    if (ss_fall) begin
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_shift <= next_frame;
                        tx_sent  <= tx_avail;
                        SPI_MISO <= next_frame[0];
                    end
                end
                ST_SHIFT: begin
                    if (sample_edge) begin
                        rx_shift <= {mosi_q[1], rx_shift[FRAME_W-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    if (shift_edge) SPI_MISO <= tx_shift[bit_cnt[IDX_W-1:0]];
                end
                ST_COMMIT: begin
                    SPI_MISO    <= 1'b0;
                    rx_overflow <= unlocked && rx_full;
                end
                default: SPI_MISO <= 1'b0;
            endcase
        end
    end

    assign rx_push  = commit && unlocked && !rx_full;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_valid = !rx_empty;
    assign tx_pop   = commit && tx_sent;
    assign tx_push  = tx_valid && tx_ready;
    assign tx_ready = !tx_full && !reset;

    sync_fifo #(.WIDTH(FRAME_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rx_pop),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sync_fifo #(.WIDTH(PAY_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench for spi_slave_fifo: one instance per CPOL/CPHA mode, instance 0 is mode 0.
// Also exercises the SPI_SLAVE_INIT_OPCODE_EN unlock sequence when that macro is defined.
module tb_spi_slave_fifo;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sck;
    logic [3:0]  ss;
    logic        mosi;
    logic [3:0]  miso;
    logic [3:0]  tx_valid;
    logic [3:0]  tx_ready;
    logic [23:0] tx_data;
    logic [3:0]  rx_valid;
    logic [3:0]  rx_ready;
    logic [31:0] rx_data [4];
    logic [3:0]  rx_overflow;

    int checks   = 0;
    int failures = 0;
    int ovf_cnt  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_fifo #(.CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .SPI_SCK     (sck[g]),
            .SPI_SS      (ss[g]),
            .SPI_MOSI    (mosi),
            .SPI_MISO    (miso[g]),
            .tx_valid    (tx_valid[g]),
            .tx_ready    (tx_ready[g]),
            .tx_data     (tx_data),
            .rx_valid    (rx_valid[g]),
            .rx_ready    (rx_ready[g]),
            .rx_data     (rx_data[g]),
            .rx_overflow (rx_overflow[g])
        );
    end

    always @(posedge clk) if (rx_overflow[0]) ovf_cnt <= ovf_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start(input int m);
        sck[m] = m[1];
        ss[m]  = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_bit(input int m, input logic b, output logic s);
        if (m[0] == 1'b0) begin
            mosi   = b;
            wait_clk(HALF);
            sck[m] = ~m[1];
            s      = miso[m];
            wait_clk(HALF);
            sck[m] = m[1];
        end else begin
            sck[m] = ~m[1];
            mosi   = b;
            wait_clk(HALF);
            sck[m] = m[1];
            s      = miso[m];
            wait_clk(HALF);
        end
    endtask

    task automatic spi_end(input int m);
        wait_clk(HALF);
        ss[m] = 1'b1;
        wait_clk(4 * HALF);
    endtask

    task automatic spi_xfer(input int m, input logic [31:0] w, input int n, output logic [31:0] r);
        logic s;
        r = '0;
        spi_start(m);
        for (int i = 0; i < n; i++) begin
            spi_bit(m, w[i], s);
            r[i] = s;
        end
        spi_end(m);
    endtask

    task automatic tx_push(input logic [23:0] d);
        tx_data     = d;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
    endtask

    task automatic rx_pop(input int m, input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, {31'b0, rx_valid[m]}, 32'd1);
        check({tag, "_data"}, rx_data[m], exp);
        rx_ready[m] = 1'b1;
        @(negedge clk);
        rx_ready[m] = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic        s;
        reset    = 1'b1;
        sck      = 4'b1100;
        ss       = 4'hF;
        mosi     = 1'b0;
        tx_valid = '0;
        tx_data  = '0;
        rx_ready = '0;

        wait_clk(3);
        check("rst_rx_valid", {31'b0, rx_valid[0]}, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready[0]}, 32'd0);
        check("rst_miso", {31'b0, miso[0]}, 32'd0);
        check("rst_ovf", {31'b0, rx_overflow[0]}, 32'd0);
        reset = 1'b0;
        wait_clk(4);
        check("post_rst_tx_ready", {31'b0, tx_ready[0]}, 32'd1);
        check("post_rst_rx_valid", {31'b0, rx_valid[0]}, 32'd0);

`ifdef SPI_SLAVE_INIT_OPCODE_EN
        tx_push(24'h123456);
        spi_xfer(0, 32'h00000055, 32, r);
        check("lock_miso", r, 32'h00000020);
        check("lock_no_push", {31'b0, rx_valid[0]}, 32'd0);
        spi_xfer(0, 32'h00000001, 32, r);
        check("unlock_miso", r, 32'h00000020);
        check("unlock_no_push", {31'b0, rx_valid[0]}, 32'd0);
        spi_xfer(0, 32'h00000055, 32, r);
        check("unlocked_miso", r, 32'h12345660);
        rx_pop(0, "unlocked_rx", 32'h00000055);
        for (int m = 1; m < 4; m++) spi_xfer(m, 32'h00000001, 32, r);
`endif

        // Mode 0 with a TX payload queued.
        tx_push(24'hCAFE77);
        spi_xfer(0, 32'h12345601, 32, r);
        check("m0_tx_miso", r, 32'hCAFE7760);
        rx_pop(0, "m0_tx_rx", 32'h12345601);

        // All four modes, TX empty.
        for (int m = 0; m < 4; m++) begin
            spi_xfer(m, 32'hA5A50F0F, 32, r);
            check($sformatf("mode%0d_miso", m), r, 32'h00000020);
            rx_pop(m, $sformatf("mode%0d_rx", m), 32'hA5A50F0F);
        end

        // Fill the RX FIFO, then overflow it.
        for (int i = 1; i <= 4; i++) begin
            spi_xfer(0, {8{i[3:0]}}, 32, r);
            check($sformatf("fill%0d_miso", i), r, 32'h00000020);
        end
        check("fill_no_ovf", ovf_cnt, 0);
        spi_xfer(0, 32'h55555555, 32, r);
        check("ovf_miso", r, 32'h00000000);
        check("ovf_pulses", ovf_cnt, 1);
        for (int i = 1; i <= 4; i++) rx_pop(0, $sformatf("drain%0d", i), {8{i[3:0]}});
        check("drain_empty", {31'b0, rx_valid[0]}, 32'd0);

        // Frame aborted after 13 bits keeps the TX head.
        tx_push(24'h000001);
        spi_xfer(0, 32'hFFFFFFFF, 13, r);
        check("abort_no_push", {31'b0, rx_valid[0]}, 32'd0);
        check("abort_tx_ready", {31'b0, tx_ready[0]}, 32'd1);
        spi_xfer(0, 32'h0BADF00D, 32, r);
        check("after_abort_miso", r, 32'h00000160);
        rx_pop(0, "after_abort_rx", 32'h0BADF00D);
        spi_xfer(0, 32'h00C0FFEE, 32, r);
        check("tx_drained_miso", r, 32'h00000020);
        rx_pop(0, "tx_drained_rx", 32'h00C0FFEE);

        // Reset in the middle of a frame.
        spi_xfer(0, 32'h13579BDF, 32, r);
        tx_push(24'hABCDEF);
        check("pre_rst_rx_valid", {31'b0, rx_valid[0]}, 32'd1);
        spi_start(0);
        for (int i = 0; i < 10; i++) spi_bit(0, 1'b1, s);
        reset = 1'b1;
        #1;
        check("mid_rst_rx_valid", {31'b0, rx_valid[0]}, 32'd0);
        check("mid_rst_tx_ready", {31'b0, tx_ready[0]}, 32'd0);
        check("mid_rst_miso", {31'b0, miso[0]}, 32'd0);
        check("mid_rst_ovf", {31'b0, rx_overflow[0]}, 32'd0);
        wait_clk(2);
        reset = 1'b0;
        for (int i = 10; i < 32; i++) spi_bit(0, 1'b0, s);
        spi_end(0);
        check("rest_ignored", {31'b0, rx_valid[0]}, 32'd0);
`ifdef SPI_SLAVE_INIT_OPCODE_EN
        spi_xfer(0, 32'h00000001, 32, r);
`endif
        spi_xfer(0, 32'hDEADBEEF, 32, r);
        check("post_mid_rst_miso", r, 32'h00000020);
        rx_pop(0, "post_mid_rst_rx", 32'hDEADBEEF);
        check("post_mid_rst_empty", {31'b0, rx_valid[0]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
